// File: rtl/uart_msg_tx.sv
// UART message transmitter: latches an MSG_LEN-character message and sends it as 8N1/8E1
// frames at one of two baud rates, optionally looping. Define UART_MSG_TX_PARITY_EN for even parity.
module uart_msg_tx #(
   parameter int CLK_HZ    = 48000000,
   parameter int BAUD_SLOW = 9600,
   parameter int BAUD_FAST = 38400,
   parameter int MSG_LEN   = 10,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [MSG_LEN*8-1:0] msg_i,
   input  logic                 baud_sel_i,
   input  logic                 start_i,
   input  logic                 repeat_i,
   output logic                 tx_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [7:0]           char_idx_o,
   output logic [2:0]           dbg_state_o
);

   localparam int DIV_SLOW = CLK_HZ / BAUD_SLOW;
   localparam int DIV_FAST = CLK_HZ / BAUD_FAST;
   localparam int DIV_MAX  = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
   localparam int DIV_W    = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
   localparam logic [DIV_W-1:0] DIV_SLOW_END = DIV_W'(DIV_SLOW - 1);
   localparam logic [DIV_W-1:0] DIV_FAST_END = DIV_W'(DIV_FAST - 1);
   localparam logic [7:0]       LAST_IDX     = 8'(MSG_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_MSG_TX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   state_t               state_q;
   logic [DIV_W-1:0]     div_q;
   logic [2:0]           bit_q;
   logic                 stop_q;
   logic                 start_prev_q;
   logic [MSG_LEN*8-1:0] msg_q;
   logic                 baud_sel_q;
   logic                 tx_q;
   logic                 busy_q;
   logic                 done_q;
   logic [7:0]           char_idx_q;

   logic [7:0]           cur_char;
   logic [DIV_W-1:0]     div_end;
   logic                 bit_tick;
   logic                 last_stop;

   always_comb begin
      cur_char = '0;
      for (int k = 0; k < MSG_LEN; k++) begin
         if (char_idx_q == 8'(k)) cur_char = msg_q[8*k +: 8];
      end
   end

   assign div_end   = baud_sel_q ? DIV_FAST_END : DIV_SLOW_END;
   assign bit_tick  = (div_q == div_end);
   assign last_stop = (STOP_BITS == 1) || stop_q;

   // NEXT has no cycle of its own: the decision is taken on the last stop-bit tick.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q      <= S_IDLE;
         div_q        <= '0;
         bit_q        <= '0;
         stop_q       <= 1'b0;
         start_prev_q <= 1'b0;
         msg_q        <= '0;
         baud_sel_q   <= 1'b0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         char_idx_q   <= '0;
      end else begin
         start_prev_q <= start_i;
         done_q       <= 1'b0;
         if (state_q == S_IDLE) begin
            // An edge landing in the DONE cycle is dropped on purpose.
            if (start_i && !start_prev_q && !done_q) begin
               msg_q      <= msg_i;
               baud_sel_q <= baud_sel_i;
               state_q    <= S_START;
               busy_q     <= 1'b1;
               tx_q       <= 1'b0;
               div_q      <= '0;
               char_idx_q <= '0;
            end
         end else if (!bit_tick) begin
            div_q <= div_q + 1'b1;
         end else begin
            div_q <= '0;
            case (state_q)
               S_START: begin
                  state_q <= S_DATA;
                  bit_q   <= '0;
                  tx_q    <= cur_char[0];
               end
               S_DATA: begin
                  if (bit_q == 3'd7) begin
`ifdef UART_MSG_TX_PARITY_EN
                     state_q <= S_PARITY;
                     tx_q    <= ^cur_char;
`else
                     state_q <= S_STOP;
                     stop_q  <= 1'b0;
                     tx_q    <= 1'b1;
`endif
                  end else begin
                     bit_q <= bit_q + 3'd1;
                     tx_q  <= cur_char[bit_q + 3'd1];
                  end
               end
`ifdef UART_MSG_TX_PARITY_EN
               S_PARITY: begin
                  state_q <= S_STOP;
                  stop_q  <= 1'b0;
                  tx_q    <= 1'b1;
               end
`endif
               S_STOP: begin
                  if (!last_stop) begin
                     stop_q <= 1'b1;
                  end else if (char_idx_q != LAST_IDX) begin
                     char_idx_q <= char_idx_q + 8'd1;
                     state_q    <= S_START;
                     tx_q       <= 1'b0;
                  end else if (repeat_i) begin
                     char_idx_q <= '0;
                     state_q    <= S_START;
                     tx_q       <= 1'b0;
                  end else begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     tx_q    <= 1'b1;
                  end
               end
               default: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  tx_q    <= 1'b1;
               end
            endcase
         end
      end
   end

   assign tx_o        = tx_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign char_idx_o  = char_idx_q;
   assign dbg_state_o = state_q;

endmodule
